// File: rtl/load_store_unit.sv
// Load/store execution unit: one decoded op in flight against the data RAM over req/gnt/rvalid.
// Optional LSU_MISALIGN_TRAP_EN: misaligned ops skip the bus and report misalign/misalign_addr.

package my_pkg;
   typedef enum logic [4:0] {
      I_NOP = 5'd0,
      I_LB  = 5'd1,
      I_LBU = 5'd2,
      I_LH  = 5'd3,
      I_LHU = 5'd4,
      I_LW  = 5'd5,
      I_SB  = 5'd6,
      I_SH  = 5'd7,
      I_SW  = 5'd8,
      I_ADD = 5'd9,
      I_SUB = 5'd10,
      I_AND = 5'd11,
      I_OR  = 5'd12,
      I_XOR = 5'd13,
      I_BEQ = 5'd14,
      I_JAL = 5'd15
   } i_type;
endpackage

// state  | meaning
// S_IDLE | ready for a new op from dispatch
// S_REQ  | bus request held until mem_gnt
// S_RESP | waiting for mem_rvalid
// S_WB   | writeback offered until wb_ready
module load_store_unit
   import my_pkg::*;
#(
   parameter int MEM_SIZE = 131072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  i_type       in_op,
   input  logic [31:0] in_base,
   input  logic [31:0] in_offset,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic        misalign,
   output logic [31:0] misalign_addr
`endif
);

   // Word-aligned physical address: ea mod MEM_SIZE with the lane bits cleared.
   localparam logic [31:0] ADDR_MASK = 32'(MEM_SIZE - 1) & ~32'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_WB   = 2'd3
   } state_e;

   state_e      state_q, state_d;
   i_type       op_q, op_d;
   logic [31:0] ea_q, ea_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic [31:0] ea_in;
   logic        skip_bus;
   logic        wb_mis;

   function automatic logic is_load(input i_type op);
      return (op == I_LB) || (op == I_LBU) || (op == I_LH) || (op == I_LHU) || (op == I_LW);
   endfunction

   function automatic logic is_store(input i_type op);
      return (op == I_SB) || (op == I_SH) || (op == I_SW);
   endfunction

   function automatic logic [3:0] store_be(input i_type op, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'hF;
      case (op)
         I_SB:    be = 4'b0001 << lane;
         I_SH:    be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'hF;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(input i_type op, input logic [31:0] rs2);
      logic [31:0] d;
      d = '0;
      case (op)
         I_SB:    d = {4{rs2[7:0]}};
         I_SH:    d = {2{rs2[15:0]}};
         I_SW:    d = rs2;
         default: d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extract(input i_type op, input logic [1:0] lane,
                                                input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         I_LB:    r = {{24{b[7]}}, b};
         I_LBU:   r = {24'b0, b};
         I_LH:    r = {{16{h[15]}}, h};
         I_LHU:   r = {16'b0, h};
         I_LW:    r = rdata;
         default: r = '0;
      endcase
      return r;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input i_type op, input logic [1:0] lane);
      logic half, word;
      half = (op == I_LH) || (op == I_LHU) || (op == I_SH);
      word = (op == I_LW) || (op == I_SW);
      return (half && lane[0]) || (word && (lane != 2'b00));
   endfunction

   assign skip_bus = is_misaligned(in_op, ea_in[1:0]);
   assign wb_mis   = is_misaligned(op_q, ea_q[1:0]);
`else
   assign skip_bus = 1'b0;
   assign wb_mis   = 1'b0;
`endif

   assign ea_in = in_base + in_offset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = ((is_load(in_op) || is_store(in_op)) && !skip_bus) ? S_REQ : S_WB;
            end
         end
         S_REQ:   if (mem_gnt)    state_d = S_RESP;
         S_RESP:  if (mem_rvalid) state_d = S_WB;
         S_WB:    if (wb_ready)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      op_d      = op_q;
      ea_d      = ea_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      wb_data_d = wb_data_q;
      if (state_q == S_IDLE && in_valid) begin
         op_d      = in_op;
         ea_d      = ea_in;
         wdata_d   = in_wdata;
         rd_d      = in_rd;
         wb_data_d = '0;
      end else if (state_q == S_RESP && mem_rvalid) begin
         wb_data_d = load_extract(op_q, ea_q[1:0], mem_rdata);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= I_NOP;
         ea_q      <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         wb_data_q <= '0;
      end else begin
         op_q      <= op_d;
         ea_q      <= ea_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      wb_valid  = 1'b0;
      wb_we     = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign      = 1'b0;
      misalign_addr = '0;
`endif
      case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_REQ: begin
            mem_req   = 1'b1;
            mem_we    = is_store(op_q);
            mem_be    = store_be(op_q, ea_q[1:0]);
            mem_addr  = ea_q & ADDR_MASK;
            mem_wdata = store_data(op_q, wdata_q);
         end
         S_WB: begin
            wb_valid = 1'b1;
            wb_we    = is_load(op_q) && (rd_q != 5'd0) && !wb_mis;
            wb_rd    = wb_we ? rd_q : 5'd0;
            wb_data  = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign      = wb_mis;
            misalign_addr = wb_mis ? ea_q : 32'd0;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle corner sequences,
// and randomized ops against a spec-level reference model.
module tb_load_store_unit;
   import my_pkg::*;

   localparam int MEM_SIZE = 131072;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   i_type       in_op;
   logic [31:0] in_base, in_offset, in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid, wb_ready, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
   logic [31:0] misalign_addr;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
      , .misalign(misalign), .misalign_addr(misalign_addr)
`endif
   );

   typedef struct {
      i_type       op;
      logic [31:0] base, off, wd;
      logic [4:0]  rd;
      logic [31:0] rdata;
      bit          mem;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr, mwdata;
      bit          wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      bit          mis;
      logic [31:0] ea;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input i_type op, input logic [31:0] base, input logic [31:0] off,
                               input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                               input bit mem, input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] mwdata, input bit wbwe,
                               input logic [4:0] wbrd, input logic [31:0] wbdata);
      vec_t v;
      v.op = op; v.base = base; v.off = off; v.wd = wd; v.rd = rd; v.rdata = rdata;
      v.mem = mem; v.we = we; v.be = be; v.addr = addr; v.mwdata = mwdata;
      v.wb_we = wbwe; v.wb_rd = wbrd; v.wb_data = wbdata; v.mis = 1'b0; v.ea = base + off;
      return v;
   endfunction

   // Reference: derives everything from the op rules with plain arithmetic.
   function automatic vec_t model(input vec_t v);
      longint unsigned ea, lane, phys, bv, hv, word;
      bit ld, st, half, wrd;
      ea   = (64'(v.base) + 64'(v.off)) % 64'h1_0000_0000;
      lane = ea % 4;
      phys = ea % MEM_SIZE;
      ld   = v.op inside {I_LB, I_LBU, I_LH, I_LHU, I_LW};
      st   = v.op inside {I_SB, I_SH, I_SW};
      half = v.op inside {I_LH, I_LHU, I_SH};
      wrd  = v.op inside {I_LW, I_SW};
      v.ea  = 32'(ea);
      v.mis = TRAP && ((half && (ea % 2 != 0)) || (wrd && lane != 0));
      v.mem = (ld || st) && !v.mis;
      v.we  = st && v.mem;
      v.addr = 0; v.be = 0; v.mwdata = 0;
      if (v.mem) begin
         v.addr = 32'(phys - phys % 4);
         v.be   = 4'hF;
         if (v.op == I_SB) begin
            v.be = 4'(1 << lane);
            v.mwdata = 32'((64'(v.wd) % 256) * 64'h0101_0101);
         end else if (v.op == I_SH) begin
            v.be = 4'(3 << (2 * (lane / 2)));
            v.mwdata = 32'((64'(v.wd) % 65536) * 64'h0001_0001);
         end else if (v.op == I_SW) begin
            v.mwdata = v.wd;
         end
      end
      v.wb_we = 0; v.wb_rd = 0; v.wb_data = 0;
      if (ld && !v.mis) begin
         word = 64'(v.rdata);
         bv   = (word >> (8 * lane)) % 256;
         hv   = (word >> (16 * (lane / 2))) % 65536;
         case (v.op)
            I_LB:    v.wb_data = 32'(bv >= 128 ? bv + 64'hFFFF_FF00 : bv);
            I_LBU:   v.wb_data = 32'(bv);
            I_LH:    v.wb_data = 32'(hv >= 32768 ? hv + 64'hFFFF_0000 : hv);
            I_LHU:   v.wb_data = 32'(hv);
            default: v.wb_data = v.rdata;
         endcase
         v.wb_we = (v.rd != 0);
         v.wb_rd = v.wb_we ? v.rd : 5'd0;
      end
      return v;
   endfunction

   // One op end to end at zero-wait timing plus the given grant / ready stalls.
   task automatic do_op(input vec_t v, input int gnt_dly, input int rdy_dly, input bit hold,
                        input bit stray);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = v.op; in_base = v.base; in_offset = v.off;
      in_wdata = v.wd; in_rd = v.rd;
      @(negedge clk);
      if (hold) begin
         in_op = I_LW; in_base = $urandom; in_offset = $urandom; in_wdata = $urandom;
         in_rd = 5'($urandom);
      end else begin
         in_valid = 1'b0;
      end
      if (v.mem) begin
         for (int k = 0; k <= gnt_dly; k++) begin
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("mem_addr", mem_addr, v.addr);
            chk("mem_be", 32'(mem_be), 32'(v.be));
            chk("mem_we", 32'(mem_we), 32'(v.we));
            chk("mem_wdata", mem_wdata, v.mwdata);
            chk("req_wb_valid", 32'(wb_valid), 32'd0);
            mem_gnt    = (k == gnt_dly);
            mem_rvalid = stray && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            @(negedge clk);
         end
         mem_gnt = 1'b0;
         chk("resp_req_drop", 32'(mem_req), 32'd0);
         chk("resp_wb_valid", 32'(wb_valid), 32'd0);
         mem_rvalid = 1'b1; mem_rdata = v.rdata;
         @(negedge clk);
         mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      for (int k = 0; k <= rdy_dly; k++) begin
         chk("wb_valid", 32'(wb_valid), 32'd1);
         chk("wb_we", 32'(wb_we), 32'(v.wb_we));
         chk("wb_rd", 32'(wb_rd), 32'(v.wb_rd));
         chk("wb_data", wb_data, v.wb_data);
         chk("wb_in_ready", 32'(in_ready), 32'd0);
         chk("wb_mem_req", 32'(mem_req), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
         chk("misalign", 32'(misalign), 32'(v.mis));
         chk("misalign_addr", misalign_addr, v.mis ? v.ea : 32'd0);
`endif
         wb_ready   = (k == rdy_dly);
         mem_rvalid = stray && ($urandom_range(0, 1) == 1);
         @(negedge clk);
      end
      wb_ready = 1'b0; mem_rvalid = 1'b0; in_valid = 1'b0;
      chk("post_wb_valid", 32'(wb_valid), 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      reset = 1'b1; in_valid = 0; in_op = I_NOP; in_base = 0; in_offset = 0; in_wdata = 0;
      in_rd = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; wb_ready = 0;

      // op, base, off, rs2, rd, rdata | mem, we, be, addr, mwdata, wb_we, wb_rd, wb_data
      tbl.push_back(mk(I_LW,  32'h100, 32'h4, 0, 5, 32'hDEADBEEF, 1, 0, 4'hF, 32'h104, 0, 1, 5, 32'hDEADBEEF));
      tbl.push_back(mk(I_LB,  32'h200, 32'h3, 0, 3, 32'h80123456, 1, 0, 4'hF, 32'h200, 0, 1, 3, 32'hFFFFFF80));
      tbl.push_back(mk(I_LBU, 32'h200, 32'h3, 0, 4, 32'h80123456, 1, 0, 4'hF, 32'h200, 0, 1, 4, 32'h00000080));
      tbl.push_back(mk(I_SH,  32'h300, 32'h2, 32'h1234ABCD, 9, 0, 1, 1, 4'hC, 32'h300, 32'hABCDABCD, 0, 0, 0));
      tbl.push_back(mk(I_SB,  32'h100, 32'h1, 32'h000000A5, 1, 0, 1, 1, 4'h2, 32'h100, 32'hA5A5A5A5, 0, 0, 0));
      tbl.push_back(mk(I_SW,  32'h400, 32'h0, 32'hCAFEF00D, 2, 0, 1, 1, 4'hF, 32'h400, 32'hCAFEF00D, 0, 0, 0));
      tbl.push_back(mk(I_LH,  32'h100, 32'h2, 0, 6, 32'h80017FFF, 1, 0, 4'hF, 32'h100, 0, 1, 6, 32'hFFFF8001));
      tbl.push_back(mk(I_LHU, 32'h100, 32'h0, 0, 7, 32'h1234F00F, 1, 0, 4'hF, 32'h100, 0, 1, 7, 32'h0000F00F));
      tbl.push_back(mk(I_LW,  32'h20, 32'h0, 0, 0, 32'h12345678, 1, 0, 4'hF, 32'h20, 0, 0, 0, 32'h12345678));
      tbl.push_back(mk(I_LW,  32'hFFFFFFFC, 32'h8, 0, 2, 32'h0BADF00D, 1, 0, 4'hF, 32'h4, 0, 1, 2, 32'h0BADF00D));
      tbl.push_back(mk(I_LW,  32'h20000, 32'h10, 0, 12, 32'h5A5A0101, 1, 0, 4'hF, 32'h10, 0, 1, 12, 32'h5A5A0101));
      tbl.push_back(mk(I_LBU, 32'h1000, 32'hFFFFFFF2, 0, 8, 32'h11223344, 1, 0, 4'hF, 32'hFF0, 0, 1, 8, 32'h22));
      tbl.push_back(mk(I_ADD, 32'h5, 32'h6, 32'h77, 7, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(i_type'(5'd20), 32'h8, 32'h0, 32'h1, 31, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
`ifndef LSU_MISALIGN_TRAP_EN
      tbl.push_back(mk(I_LW,  32'h1FFF0, 32'hE, 0, 10, 32'h89ABCDEF, 1, 0, 4'hF, 32'h1FFFC, 0, 1, 10, 32'h89ABCDEF));
      tbl.push_back(mk(I_LH,  32'h100, 32'h3, 0, 11, 32'hFEDC1234, 1, 0, 4'hF, 32'h100, 0, 1, 11, 32'hFFFFFEDC));
      tbl.push_back(mk(I_SH,  32'h100, 32'h1, 32'h00005678, 4, 0, 1, 1, 4'h3, 32'h100, 32'h56785678, 0, 0, 0));
      tbl.push_back(mk(I_SW,  32'h200, 32'h3, 32'h01020304, 4, 0, 1, 1, 4'hF, 32'h200, 32'h01020304, 0, 0, 0));
`endif

      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) do_op(tbl[i], 0, 0, 1'b0, 1'b0);

      // Grant stalled 3 cycles, regfile stalls 2 cycles, dispatch keeps in_valid high.
      do_op(tbl[0], 3, 2, 1'b1, 1'b1);
      do_op(tbl[3], 2, 1, 1'b1, 1'b0);

      // Reset during RESP, then a late rvalid must not produce a writeback.
      in_valid = 1'b1; in_op = I_LW; in_base = 32'h40; in_offset = 0; in_rd = 5'd3;
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("abort_in_resp", 32'(mem_req), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("abort_no_wb", 32'(wb_valid), 32'd0);
         chk("abort_idle", 32'(in_ready), 32'd1);
         @(negedge clk);
      end
      do_op(tbl[1], 0, 0, 1'b0, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
      v = mk(I_LW, 32'h1FFF0, 32'hE, 0, 10, 32'h89ABCDEF, 0, 0, 0, 0, 0, 0, 0, 0);
      v.mis = 1'b1;
      do_op(v, 0, 1, 1'b0, 1'b0);
      v = mk(I_SH, 32'h101, 32'h0, 32'h1111, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.mis = 1'b1;
      do_op(v, 0, 0, 1'b0, 1'b0);
`endif

      for (int n = 0; n < 200; n++) begin
         int sel;
         sel = $urandom_range(0, 10);
         case (sel)
            0: v.op = I_LB;  1: v.op = I_LBU; 2: v.op = I_LH;  3: v.op = I_LHU;
            4: v.op = I_LW;  5: v.op = I_SB;  6: v.op = I_SH;  7: v.op = I_SW;
            8: v.op = I_ADD; 9: v.op = i_type'(5'($urandom_range(16, 31)));
            default: v.op = I_LW;
         endcase
         v.base  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h3FFFF));
         v.off   = 32'($urandom_range(0, 4095)) - 32'd2048;
         v.wd    = $urandom;
         v.rd    = 5'($urandom_range(0, 31));
         v.rdata = $urandom;
         v = model(v);
         do_op(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
